// File: rtl/cache_types_pkg.sv
// Shared types and default geometry for the cache-to-memory burst adaptor.
package cache_types_pkg;

  localparam int unsigned DEFAULT_LINE_W  = 256;
  localparam int unsigned DEFAULT_BURST_W = 64;
  localparam int unsigned DEFAULT_ADDR_W  = 32;

  localparam int unsigned BEATS       = DEFAULT_LINE_W / DEFAULT_BURST_W;
  localparam int unsigned OFFSET_BITS = $clog2(DEFAULT_LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD_BURST = 2'b01,
    WR_BURST = 2'b10,
    DONE     = 2'b11
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single-line cache read/write requests into ascending memory bursts
// and returns a one-cycle completion pulse once the whole line has moved.
module cacheline_adaptor
  import cache_types_pkg::*;
#(
  parameter int unsigned LINE_W  = DEFAULT_LINE_W,
  parameter int unsigned BURST_W = DEFAULT_BURST_W,
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned NumBeats = LINE_W / BURST_W;
  localparam int unsigned CntW     = $clog2(NumBeats);
  localparam int unsigned OffBits  = $clog2(LINE_W / 8);

  adaptor_state_t    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_beat;

  assign last_beat = (cnt_q == CntW'(NumBeats - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        // Write takes priority if both requests are raised together.
        if (pmem_write) begin
          addr_d  = {pmem_address[ADDR_W-1:OffBits], {OffBits{1'b0}}};
          buf_d   = pmem_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end else if (pmem_read) begin
          addr_d  = {pmem_address[ADDR_W-1:OffBits], {OffBits{1'b0}}};
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (mem_resp) begin
          buf_d[cnt_q*BURST_W +: BURST_W] = mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  // Every output comes from registers only; no request input reaches mem_* directly.
  assign mem_read    = (state_q == RD_BURST);
  assign mem_write   = (state_q == WR_BURST);
  assign pmem_resp   = (state_q == DONE);
  assign pmem_rdata  = buf_q;
  assign mem_address = addr_q;
  assign mem_wdata   = buf_q[cnt_q*BURST_W +: BURST_W];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed, table-driven bench for cacheline_adaptor at default geometry.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst_n;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_checks = 0;
  int n_errors = 0;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        resp;
    logic [31:0] addr;
    logic [63:0] rdata;
    logic        e_mrd;
    logic        e_mwr;
    logic        e_presp;
    logic        chk_wd;
    logic [63:0] e_wd;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic resp,
                              input logic [31:0] addr, input logic [63:0] rdata,
                              input logic e_mrd, input logic e_mwr, input logic e_presp,
                              input logic chk_wd, input logic [63:0] e_wd,
                              input logic [31:0] e_addr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.resp = resp; v.addr = addr; v.rdata = rdata;
    v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_presp = e_presp;
    v.chk_wd = chk_wd; v.e_wd = e_wd; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [63:0]  d [4];
  logic [63:0]  r [4];
  logic [63:0]  y [4];
  logic [255:0] wline, rline, eline, fline, yline;
  vec_t         tbl [$];
  localparam logic [31:0] Junk = 32'hFFFF_FFFF;
  localparam logic [63:0] Bad  = 64'hBAD0_BAD0_BAD0_BAD0;

  initial begin
    d[0] = 64'hD000_0000_0000_00D0; d[1] = 64'hD111_0000_0000_01D1;
    d[2] = 64'hD222_0000_0000_02D2; d[3] = 64'hD333_0000_0000_03D3;
    r[0] = 64'h1111_1111_1111_1111; r[1] = 64'h2222_2222_2222_2222;
    r[2] = 64'h3333_3333_3333_3333; r[3] = 64'h4444_4444_4444_4444;
    y[0] = 64'hA5A5_0000_0000_0001; y[1] = 64'hA5A5_0000_0000_0002;
    y[2] = 64'hA5A5_0000_0000_0003; y[3] = 64'hA5A5_0000_0000_0004;
    wline = {d[3], d[2], d[1], d[0]};
    rline = {r[3], r[2], r[1], r[0]};
    yline = {y[3], y[2], y[1], y[0]};
    eline = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
             64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
    fline = {64'hF3F3_0000_0000_0003, 64'hF2F2_0000_0000_0002,
             64'hF1F1_0000_0000_0001, 64'hF0F0_0000_0000_0000};

    // Write with gapped beats, stray resps in DONE and IDLE, then a back-to-back read.
    //           rd    wr    resp  addr          rdata  mrd   mwr   presp chkwd wd    e_addr
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_805F, Bad, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[0], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[0], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[1], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[1], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[2], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[3], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[3], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, Junk, Bad, 1'b0, 1'b1, 1'b0, 1'b1, d[3], 32'h8040));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, Junk, Bad, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, Junk, Bad, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, Junk, Bad, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000_1234, Bad, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, Junk, r[0], 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h1220));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, Junk, r[1], 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h1220));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, Junk, r[2], 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h1220));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, Junk, r[3], 1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h1220));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, Junk, Bad, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, Junk, Bad, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));

    rst_n = 1'b0;
    pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    #2;
    chk("reset pmem_resp", 256'(pmem_resp), 256'(0));
    chk("reset mem_read", 256'(mem_read), 256'(0));
    chk("reset mem_write", 256'(mem_write), 256'(0));
    chk("reset pmem_rdata", pmem_rdata, '0);
    chk("reset mem_address", 256'(mem_address), 256'(0));
    chk("reset mem_wdata", 256'(mem_wdata), 256'(0));
    #10 rst_n = 1'b1;
    step();

    pmem_wdata = wline;
    for (int i = 0; i < tbl.size(); i++) begin
      pmem_read = tbl[i].rd; pmem_write = tbl[i].wr; mem_resp = tbl[i].resp;
      pmem_address = tbl[i].addr; mem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d mem_read", i), 256'(mem_read), 256'(tbl[i].e_mrd));
      chk($sformatf("row%0d mem_write", i), 256'(mem_write), 256'(tbl[i].e_mwr));
      chk($sformatf("row%0d pmem_resp", i), 256'(pmem_resp), 256'(tbl[i].e_presp));
      if (tbl[i].chk_wd) chk($sformatf("row%0d mem_wdata", i), 256'(mem_wdata), 256'(tbl[i].e_wd));
      if (tbl[i].e_mrd || tbl[i].e_mwr)
        chk($sformatf("row%0d mem_address", i), 256'(mem_address), 256'(tbl[i].e_addr));
      step();
    end
    mem_resp = 1'b0;
    chk("read line held", pmem_rdata, rline);

    // Write right after a read: buffer must be replaced at acceptance.
    pmem_write = 1'b1; pmem_address = 32'h0000_2000; pmem_wdata = eline;
    step();
    chk("b2b mem_write", 256'(mem_write), 256'(1));
    chk("b2b buffer overwritten", pmem_rdata, eline);
    chk("b2b mem_address", 256'(mem_address), 256'(32'h2000));
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("b2b beat%0d mem_wdata", b), 256'(mem_wdata), 256'(eline[b*64 +: 64]));
      mem_resp = 1'b1;
      step();
    end
    mem_resp = 1'b0;
    chk("b2b pmem_resp", 256'(pmem_resp), 256'(1));
    pmem_write = 1'b0;
    step();

    // Both requests at once: write must win.
    pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_3000; pmem_wdata = fline;
    step();
    chk("both mem_write", 256'(mem_write), 256'(1));
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("both beat%0d mem_read", b), 256'(mem_read), 256'(0));
      chk($sformatf("both beat%0d mem_wdata", b), 256'(mem_wdata), 256'(fline[b*64 +: 64]));
      mem_resp = 1'b1;
      step();
    end
    mem_resp = 1'b0;
    chk("both pmem_resp", 256'(pmem_resp), 256'(1));
    chk("both mem_write off", 256'(mem_write), 256'(0));
    pmem_read = 1'b0; pmem_write = 1'b0;
    step();
    chk("both idle pmem_resp", 256'(pmem_resp), 256'(0));

    // Asynchronous reset after two read beats.
    pmem_read = 1'b1; pmem_address = 32'h0000_4444;
    step();
    mem_resp = 1'b1; mem_rdata = r[0];
    step();
    mem_rdata = r[1];
    step();
    mem_resp = 1'b0;
    chk("pre-reset mem_read", 256'(mem_read), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async mem_read", 256'(mem_read), 256'(0));
    chk("async pmem_resp", 256'(pmem_resp), 256'(0));
    chk("async pmem_rdata", pmem_rdata, '0);
    chk("async mem_address", 256'(mem_address), 256'(0));
    chk("async mem_wdata", 256'(mem_wdata), 256'(0));
    pmem_read = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    chk("post-reset pmem_resp", 256'(pmem_resp), 256'(0));
    chk("post-reset mem_read", 256'(mem_read), 256'(0));

    pmem_read = 1'b1; pmem_address = 32'h0000_5560;
    step();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("rr beat%0d mem_read", b), 256'(mem_read), 256'(1));
      chk($sformatf("rr beat%0d pmem_resp", b), 256'(pmem_resp), 256'(0));
      mem_resp = 1'b1; mem_rdata = y[b];
      step();
    end
    mem_resp = 1'b0;
    chk("rr pmem_resp", 256'(pmem_resp), 256'(1));
    chk("rr pmem_rdata", pmem_rdata, yline);
    chk("rr mem_address", 256'(mem_address), 256'(32'h5560));
    pmem_read = 1'b0;
    step();
    chk("rr idle pmem_resp", 256'(pmem_resp), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
